// File: rtl/md_sequencer_pkg.sv
// Shared encodings and default latencies for the E-stage multiply/divide sequencer.
package md_sequencer_pkg;

    localparam int MD_DATA_W       = 32;
    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    typedef enum logic [3:0] {
        MD_FREE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mult(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; result is {hi, lo}.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [3:0]            op,
    input  logic [MD_DATA_W-1:0]  a,
    input  logic [MD_DATA_W-1:0]  b,
    output logic [2*MD_DATA_W-1:0] result,
    output logic                  div0
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic        [31:0] den_s;
    logic        [31:0] den_u;
    logic               b_zero;
    logic               s_ovf;

    always_comb begin
        a_sx   = {{32{a[31]}}, a};
        b_sx   = {{32{b[31]}}, b};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, a} * {32'd0, b};

        b_zero = (b == 32'd0);
        s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Divisors are steered away from zero and the signed overflow pair
        // so the dividers never see an undefined case; those results are replaced below.
        den_s  = (b_zero || s_ovf) ? 32'd1 : b;
        den_u  = b_zero ? 32'd1 : b;

        quo_s  = $signed(a) / $signed(den_s);
        rem_s  = $signed(a) % $signed(den_s);
        quo_u  = a / den_u;
        rem_u  = a % den_u;

        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = s_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
            MD_DIVU:  result = {rem_u, quo_u};
            default:  result = 64'd0;
        endcase

        div0 = ((op == MD_DIV) || (op == MD_DIVU)) && b_zero;
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer: latency counter, HI/LO registers,
// mfhi/mflo read path and MD stall toward IF/ID.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        id_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] MDOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] arith_res;
    logic        arith_div0;
    logic        start_eff;
    logic        mt_eff;
    logic        commit;

    md_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (arith_res),
        .div0   (arith_div0)
    );

    assign busy      = (state_q == ST_RUN);
    assign start_eff = start & ~flush & ~busy & md_is_arith(MDOp);
    assign mt_eff    = ~flush & ~busy & ((MDOp == MD_MTHI) || (MDOp == MD_MTLO));
    assign md_stall  = id_md & (busy | start_eff);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_eff) begin
                    state_d = ST_RUN;
                    cnt_d   = md_is_mult(MDOp) ? MULT_CNT : DIV_CNT;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= MD_FREE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_eff) op_q <= MDOp;
            // Divide by zero leaves HI/LO untouched even though busy ran its full length.
            if (commit && !arith_div0) begin
                hi_q <= arith_res[63:32];
                lo_q <= arith_res[31:0];
            end else if (mt_eff) begin
                if (MDOp == MD_MTHI) hi_q <= A;
                else                 lo_q <= A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_eff) begin
            a_q <= A;
            b_q <= B;
        end
    end

    always_comb begin
        MDOut = 32'd0;
        if (MDOp == MD_MFHI)      MDOut = hi_q;
        else if (MDOp == MD_MFLO) MDOut = lo_q;
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, arithmetic corners, mt/mf, flush and reset.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDOp;
    logic [31:0] A, B;
    logic        flush;
    logic        id_md;
    logic        busy, md_stall;
    logic [31:0] MDOut, HI, LO;

    int n_checks = 0;
    int n_pass   = 0;

    md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
        .flush(flush), .id_md(id_md), .busy(busy), .md_stall(md_stall),
        .MDOut(MDOut), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one arithmetic op and follow it through its busy window.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic idm,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        MDOp = op; A = a; B = b; start = 1'b1; id_md = idm;
        #1;
        check({tag, "_busy_T"}, busy, 0);
        check({tag, "_stall_T"}, md_stall, idm);
        tick();
        start = 1'b0; MDOp = MD_FREE; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
        #1;
        for (int i = 1; i <= lat; i++) begin
            check($sformatf("%s_busy_T+%0d", tag, i), busy, 1);
            check($sformatf("%s_stall_T+%0d", tag, i), md_stall, idm);
            tick();
        end
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_stall_done"}, md_stall, 0);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
        id_md = 1'b0;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        MDOp = op; A = val;
        tick();
        MDOp = MD_FREE;
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; MDOp = MD_FREE; A = '0; B = '0; flush = 1'b0; id_md = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_stall", md_stall, 0);
        reset = 1'b1;
        tick();

        // 1-3: multiply and divide results
        run_op("mult",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  MD_DIVU,  32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC);

        // 4: mt, divide by zero, mf
        mt(MD_MTHI, 32'h11);
        check("mthi_11", HI, 32'h11);
        mt(MD_MTLO, 32'h22);
        check("mtlo_22", LO, 32'h22);
        run_op("div0", MD_DIV, 32'd100, 32'd0, 10, 1'b0, 32'h11, 32'h22);
        mt(MD_MTHI, 32'h55);
        check("mthi_55", HI, 32'h55);
        MDOp = MD_MFHI; #1;
        check("mfhi", MDOut, 32'h55);
        MDOp = MD_MFLO; #1;
        check("mflo", MDOut, 32'h22);
        MDOp = MD_FREE; #1;
        check("mdout_free", MDOut, 32'h0);

        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0, 32'h8000_0000);

        // 5: flush suppresses start and mt; start while busy ignored; flush while busy harmless
        MDOp = MD_MULT; A = 32'd9; B = 32'd9; start = 1'b1; flush = 1'b1; id_md = 1'b1;
        #1;
        check("flush_stall", md_stall, 0);
        tick();
        check("flush_busy", busy, 0);
        MDOp = MD_MTHI; A = 32'h77; start = 1'b0;
        tick();
        check("flush_mt_hi", HI, 32'h0);
        check("flush_lo", LO, 32'h8000_0000);
        flush = 1'b0; id_md = 1'b0;

        MDOp = MD_MULT; A = 32'd2; B = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; MDOp = MD_FREE;
        tick();
        $display("note: protocol violation, start issued while busy (expected to be ignored)");
        MDOp = MD_MULT; A = 32'd7; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; MDOp = MD_MTLO; A = 32'h99;
        tick();
        MDOp = MD_FREE; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("second_busy_T+5", busy, 1);
        tick();
        check("second_busy_T+6", busy, 0);
        check("second_hi", HI, 32'h0);
        check("second_lo", LO, 32'h6);
        for (int i = 0; i < 8; i++) tick();
        check("second_no_commit_busy", busy, 0);
        check("second_no_commit_lo", LO, 32'h6);

        // 6: reset mid-divide discards the op
        mt(MD_MTHI, 32'h99);
        MDOp = MD_DIV; A = 32'd100; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; MDOp = MD_FREE;
        tick(); tick();
        check("rstmid_busy_T+3", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rstmid_busy", busy, 0);
        check("rstmid_hi", HI, 32'h0);
        check("rstmid_lo", LO, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        check("rstmid_late_busy", busy, 0);
        check("rstmid_late_hi", HI, 32'h0);
        check("rstmid_late_lo", LO, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
